// File: rtl/sam_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sam_controller: hardwired SAM accumulator CPU control unit producing the |
// | 22-bit datapath control word b. Define SAM_CTRL_DEBUG_EN for state_dbg.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sam_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        WAIT,
  input  logic        IR15,
  input  logic        AC15,
  input  logic        IR14,
  output logic [21:0] b
`ifdef SAM_CTRL_DEBUG_EN
  ,
  output logic [3:0]  state_dbg
`endif
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_REQ   = 4'd2,
    S_F_WAIT  = 4'd3,
    S_F_IR    = 4'd4,
    S_DECODE  = 4'd5,
    S_OP_REQ  = 4'd6,
    S_OP_WAIT = 4'd7,
    S_EX1     = 4'd8,
    S_EX2     = 4'd9,
    S_ST_MBR  = 4'd10,
    S_ST_REQ  = 4'd11,
    S_ST_WAIT = 4'd12,
    S_BR      = 4'd13
  } state_t;

  localparam logic [21:0] B_RST      = 22'h000040;
  localparam logic [21:0] B_F_ADDR   = 22'h200400;
  localparam logic [21:0] B_RD_REQ   = 22'h00200C;
  localparam logic [21:0] B_RD_WAIT  = 22'h00220C;
  localparam logic [21:0] B_F_IR     = 22'h080820;
  localparam logic [21:0] B_DECODE   = 22'h100400;
  localparam logic [21:0] B_EX_LOAD  = 22'h014080;
  localparam logic [21:0] B_EX_ADD   = 22'h038080;
  localparam logic [21:0] B_EX2_ADD  = 22'h040001;
  localparam logic [21:0] B_ST_MBR   = 22'h000102;
  localparam logic [21:0] B_WR_CYCLE = 22'h003004;
  localparam logic [21:0] B_BRANCH   = 22'h100010;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [1:0]  opcode;
  logic [21:0] ex_word;

  assign opcode  = {IR15, IR14};
  // EX1 and EX2 share the operand word; IR15 alone separates ADD from LOAD there
  assign ex_word = IR15 ? B_EX_ADD : B_EX_LOAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_RST;
    b          = B_RST;
    case (state)
      S_RST: begin
        next_state = S_F_ADDR;
        b          = B_RST;
      end
      S_F_ADDR: begin
        next_state = S_F_REQ;
        b          = B_F_ADDR;
      end
      S_F_REQ: begin
        next_state = S_F_WAIT;
        b          = B_RD_REQ;
      end
      S_F_WAIT: begin
        next_state = WAIT ? S_F_WAIT : S_F_IR;
        b          = B_RD_WAIT;
      end
      S_F_IR: begin
        next_state = S_DECODE;
        b          = B_F_IR;
      end
      S_DECODE: begin
        b = B_DECODE;
        case (opcode)
          OP_LOAD, OP_ADD: next_state = S_OP_REQ;
          OP_STORE:        next_state = S_ST_MBR;
          default:         next_state = S_BR;
        endcase
      end
      S_OP_REQ: begin
        next_state = S_OP_WAIT;
        b          = B_RD_REQ;
      end
      S_OP_WAIT: begin
        next_state = WAIT ? S_OP_WAIT : S_EX1;
        b          = B_RD_WAIT;
      end
      S_EX1: begin
        next_state = S_EX2;
        b          = ex_word;
      end
      S_EX2: begin
        next_state = S_F_ADDR;
        b          = ex_word | B_EX2_ADD;
      end
      S_ST_MBR: begin
        next_state = S_ST_REQ;
        b          = B_ST_MBR;
      end
      S_ST_REQ: begin
        next_state = S_ST_WAIT;
        b          = B_WR_CYCLE;
      end
      S_ST_WAIT: begin
        next_state = WAIT ? S_ST_WAIT : S_F_ADDR;
        b          = B_WR_CYCLE;
      end
      S_BR: begin
        next_state = S_F_ADDR;
        b          = AC15 ? B_BRANCH : 22'h000000;
      end
      default: begin
        next_state = S_RST;
        b          = B_RST;
      end
    endcase
  end

`ifdef SAM_CTRL_DEBUG_EN
  assign state_dbg = state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sam_controller.sv
`default_nettype none
// Self-checking bench for sam_controller: a per-instruction cycle-list model
// built from the instruction/memory-access rules is compared against b.
module tb_sam_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        WAIT;
  logic        IR15;
  logic        AC15;
  logic        IR14;
  logic [21:0] b;
`ifdef SAM_CTRL_DEBUG_EN
  logic [3:0]  state_dbg;
`endif

  sam_controller dut (
    .clk       (clk),
    .reset     (reset),
    .WAIT      (WAIT),
    .IR15      (IR15),
    .AC15      (AC15),
    .IR14      (IR14),
    .b         (b)
`ifdef SAM_CTRL_DEBUG_EN
    ,
    .state_dbg (state_dbg)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [21:0] W_RST     = 22'h000040;
  localparam logic [21:0] W_F_ADDR  = 22'h200400;
  localparam logic [21:0] W_RD_REQ  = 22'h00200C;
  localparam logic [21:0] W_RD_WAIT = 22'h00220C;
  localparam logic [21:0] W_F_IR    = 22'h080820;
  localparam logic [21:0] W_DECODE  = 22'h100400;
  localparam logic [21:0] W_ST_MBR  = 22'h000102;
  localparam logic [21:0] W_WR      = 22'h003004;

  int compared   = 0;
  int mismatched = 0;

  // Expected cycle list: WAIT value to apply and b expected in that cycle
  logic        wq[$];
  logic [21:0] bq[$];

  task automatic push(input logic w, input logic [21:0] e);
    wq.push_back(w);
    bq.push_back(e);
  endtask

  // One memory access: a request cycle (WAIT ignored) then busy+1 wait cycles
  task automatic mem_access(input logic [21:0] req_w, input logic [21:0] wait_w, input int busy);
    push(1'($urandom_range(0, 1)), req_w);
    repeat (busy) push(1'b1, wait_w);
    push(1'b0, wait_w);
  endtask

  task automatic build_instr(input logic [1:0] op, input logic ac, input int fetch_busy, input int op_busy);
    logic [21:0] ex;
    wq.delete();
    bq.delete();
    IR15 = op[1];
    IR14 = op[0];
    AC15 = ac;
    push(1'($urandom_range(0, 1)), W_F_ADDR);
    mem_access(W_RD_REQ, W_RD_WAIT, fetch_busy);
    push(1'($urandom_range(0, 1)), W_F_IR);
    push(1'($urandom_range(0, 1)), W_DECODE);
    case (op)
      2'b00, 2'b10: begin
        // LOAD: MBR passes through ALU B; ADD: AC + MBR
        ex = (op == 2'b10) ? 22'h038080 : 22'h014080;
        mem_access(W_RD_REQ, W_RD_WAIT, op_busy);
        push(1'($urandom_range(0, 1)), ex);
        push(1'($urandom_range(0, 1)), ex | 22'h040001);
      end
      2'b01: begin
        push(1'($urandom_range(0, 1)), W_ST_MBR);
        mem_access(W_WR, W_WR, op_busy);
      end
      default: push(1'($urandom_range(0, 1)), ac ? 22'h100010 : 22'h000000);
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1;
    WAIT  = 1'b0;
    IR15  = 1'b0;
    IR14  = 1'b0;
    AC15  = 1'b0;
    #1;
    compared++;
    if (b !== W_RST) begin
      mismatched++;
      $display("FAIL reset_immediate: b=%06h expected %06h", b, W_RST);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (b !== W_RST) begin
      mismatched++;
      $display("FAIL reset_held: b=%06h expected %06h", b, W_RST);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (b !== W_RST) begin
      mismatched++;
      $display("FAIL reset_release_before_edge: b=%06h expected %06h", b, W_RST);
    end
  endtask

  task automatic test_fetch_wait;
    build_instr(2'b00, 1'b0, 3, 0);
    for (int i = 0; i < bq.size(); i++) begin
      @(posedge clk);
      #1 WAIT = wq[i];
      @(negedge clk);
      compared++;
      if (b !== bq[i]) begin
        mismatched++;
        $display("FAIL fetch_wait cycle %0d: b=%06h expected %06h", i, b, bq[i]);
      end
    end
  endtask

  task automatic test_opcodes;
    logic [1:0] ops[5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
    logic       acs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      build_instr(ops[k], acs[k], 0, (k == 2) ? 2 : 0);
      for (int i = 0; i < bq.size(); i++) begin
        @(posedge clk);
        #1 WAIT = wq[i];
        @(negedge clk);
        compared++;
        if (b !== bq[i]) begin
          mismatched++;
          $display("FAIL opcode %b ac %b cycle %0d: b=%06h expected %06h", ops[k], acs[k], i, b, bq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    build_instr(2'b10, 1'b0, 6, 0);
    // F_ADDR, F_REQ and two F_WAIT cycles, then reset inside the third
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 WAIT = wq[i];
      @(negedge clk);
      compared++;
      if (b !== bq[i]) begin
        mismatched++;
        $display("FAIL mid_reset_prefix cycle %0d: b=%06h expected %06h", i, b, bq[i]);
      end
    end
    @(posedge clk);
    #1 WAIT = 1'b1;
    #1 reset = 1'b1;
    #1;
    compared++;
    if (b !== W_RST || b[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_immediate: b=%06h expected %06h", b, W_RST);
    end
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (b !== W_RST) begin
      mismatched++;
      $display("FAIL mid_reset_held: b=%06h expected %06h", b, W_RST);
    end
    reset = 1'b0;
    build_instr(2'b00, 1'b0, 1, 1);
    for (int i = 0; i < bq.size(); i++) begin
      @(posedge clk);
      #1 WAIT = wq[i];
      @(negedge clk);
      compared++;
      if (b !== bq[i]) begin
        mismatched++;
        $display("FAIL after_mid_reset cycle %0d: b=%06h expected %06h", i, b, bq[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] op;
    logic       ac;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      ac = 1'($urandom_range(0, 1));
      build_instr(op, ac, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int i = 0; i < bq.size(); i++) begin
        @(posedge clk);
        #1 WAIT = wq[i];
        @(negedge clk);
        compared++;
        if (b !== bq[i]) begin
          mismatched++;
          $display("FAIL random instr %0d op %b ac %b cycle %0d: b=%06h expected %06h",
                   k, op, ac, i, b, bq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch_wait;
    test_opcodes;
    test_reset_mid_access;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
